// File: rtl/reg_file_param_if.sv
// rtl/reg_file_param_if.sv - write/read/clear bus between writeback, ALU operands and the register file
interface reg_file_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              RFWrite;
  logic [ADDR_W-1:0] regW;
  logic [DATA_W-1:0] dataW;
  logic [ADDR_W-1:0] regA;
  logic [ADDR_W-1:0] regB;
  logic              clear_req;
  logic [DATA_W-1:0] dataA;
  logic [DATA_W-1:0] dataB;
  logic              busy;
  logic              clear_done;

  modport master (
    output RFWrite, regW, dataW, regA, regB, clear_req,
    input  dataA, dataB, busy, clear_done
  );

  modport slave (
    input  RFWrite, regW, dataW, regA, regB, clear_req,
    output dataA, dataB, busy, clear_done
  );
endinterface

// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised 2R/1W register file with bypass, zero register and sequenced clear
module reg_file_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input logic             CLOCK_50,
  input logic             reset,
  reg_file_param_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              user_wr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Writes to the hardwired zero register are dropped here, which also keeps them off the bypass path.
  assign user_wr = (state_q == S_IDLE) && bus.RFWrite &&
                   !((ZERO_REG != 0) && (bus.regW == '0));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_en   = user_wr;
    wr_addr = bus.regW;
    wr_data = bus.dataW;
    case (state_q)
      S_IDLE: begin
        if (bus.clear_req) begin
          state_d = S_CLEAR;
          idx_d   = '0;
        end
      end
      S_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = idx_q;
        wr_data = '0;
        idx_d   = idx_q + ADDR_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              fwd_en,
    input logic [ADDR_W-1:0] fwd_addr,
    input logic [DATA_W-1:0] fwd_data
  );
    if ((ZERO_REG != 0) && (addr == '0)) begin
      return '0;
    end else if ((BYPASS != 0) && fwd_en && (addr == fwd_addr)) begin
      return fwd_data;
    end else begin
      return stored;
    end
  endfunction

  assign bus.dataA      = read_port(bus.regA, mem_q[bus.regA], user_wr, bus.regW, bus.dataW);
  assign bus.dataB      = read_port(bus.regB, mem_q[bus.regB], user_wr, bus.regW, bus.dataW);
  assign bus.busy       = (state_q == S_CLEAR);
  assign bus.clear_done = (state_q == S_DONE);
endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised successor to the 4x8 two-read/one-write register file.
- Adds configurable width and depth, an optional hardwired-zero register 0, and optional write-to-read bypass.
- Adds an asynchronous reset plus a sequenced bulk-clear engine with busy/done handshake.
- Sits in the datapath between the controller/ALU writeback and the ALU operand inputs.

Parameters:
- DATA_W, 8, register width in bits.
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 0, 1 = register 0 reads as 0 and ignores writes.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports.

Ports:
- CLOCK_50  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- RFWrite  in  1  write enable.
- regW  in  ADDR_W  write address.
- dataW  in  DATA_W  write data.
- regA  in  ADDR_W  read address, port A.
- regB  in  ADDR_W  read address, port B.
- clear_req  in  1  request to zero all registers; sampled on the rising edge.
- dataA  out  DATA_W  read data, port A; combinational.
- dataB  out  DATA_W  read data, port B; combinational.
- busy  out  1  high while the clear sequence is running.
- clear_done  out  1  one-cycle pulse when the clear sequence completes.

Behaviour:
- Reset asserted, asynchronously:
  - all DEPTH registers become 0;
  - FSM goes to IDLE and the clear index to 0;
  - busy = 0, clear_done = 0;
  - dataA/dataB therefore read 0.
- Reset deasserted mid-clear: sequence abandoned; block restarts in IDLE with all registers 0.
- Write (IDLE only):
  - on a rising edge with RFWrite=1, reg[regW] <= dataW; takes effect next cycle;
  - if ZERO_REG=1 and regW=0, the write is discarded.
- Read:
  - dataA = reg[regA], dataB = reg[regB], zero latency;
  - ZERO_REG=1 and address 0 -> output 0 regardless of storage.
- Bypass (BYPASS=1, FSM in IDLE):
  - RFWrite=1 and regA==regW (and not the zero register) -> dataA = dataW in the same cycle; same rule for B.
  - Both ports may bypass at once.
  - BYPASS=0 -> reads return the old value until the edge.
- FSM states:
  - IDLE: busy=0. clear_req=1 at an edge -> CLEAR with idx=0. A write in the same cycle still commits at that edge.
  - CLEAR: busy=1. Each edge: reg[idx] <= 0, idx <= idx+1. When idx==DEPTH-1 is written -> DONE. Clearing DEPTH registers takes DEPTH cycles.
  - DONE: busy=0, clear_done=1 for exactly this cycle; next edge -> IDLE unconditionally.
- During CLEAR:
  - RFWrite is ignored and writes are dropped; upstream must hold off while busy;
  - bypass is disabled;
  - reads return current storage (partly cleared contents);
  - clear_req is ignored.
- clear_req in DONE is ignored; it must be re-raised in IDLE.
- idx width is ADDR_W; the terminal compare prevents wrap-around.
- Total latency from the clear_req sampling edge to clear_done high is DEPTH+1 edges.
- No X on outputs after reset for any address.

Test Plan:
- Reset: assert reset asynchronously between edges with registers holding 0x5A -> dataA/dataB read 0x00 immediately; busy=0, clear_done=0.
- Basic write/read (defaults): write 0xA5 to r2, then 0x3C to r1; set regA=2, regB=1 -> dataA=0xA5, dataB=0x3C on the cycle after each write.
- Bypass: with r3=0x11, in one cycle drive RFWrite=1, regW=3, dataW=0x77, regA=3, regB=3 -> dataA=dataB=0x77 in that cycle. Rebuild with BYPASS=0 -> 0x11 in that cycle, 0x77 after the edge.
- ZERO_REG=1, DATA_W=16, ADDR_W=3:
  - write 0xBEEF to r0 -> r0 reads 0x0000, no bypass;
  - write 0xBEEF to r7 -> r7 reads 0xBEEF.
- Clear sequence (defaults, all regs 0xFF):
  - pulse clear_req together with a write of 0x42 to r1 -> the write commits;
  - busy high for 4 cycles; r0..r3 read 0 progressively; clear_done pulses once, 5 edges after the request;
  - an RFWrite of 0x99 to r2 while busy -> r2 stays 0.
- Reset mid-clear: assert reset during the 2nd CLEAR cycle -> busy=0 at once, all registers 0, no clear_done pulse; a new clear_req afterwards completes normally.
